// File: rtl/branch_pc_if.sv
// Bundle between the branch/PC unit and the rest of the pipeline.
// The master side (issue stage or bench) drives the inputs. The slave side (branch_pc_unit) returns the state.
interface branch_pc_if #(
  parameter int unsigned PCW = 10
);
  logic           stall_i;
  logic           flag_we_i;
  logic           ge_i;
  logic           ne_i;
  logic           br_valid_i;
  logic [1:0]     br_cond_i;
  logic [PCW-1:0] br_target_i;
  logic           halt_i;
  logic [PCW-1:0] pc_o;
  logic           take_o;
  logic           flush_o;
  logic           halted_o;
  logic           ge_q_o;
  logic           ne_q_o;

  modport master (
    output stall_i, flag_we_i, ge_i, ne_i, br_valid_i, br_cond_i, br_target_i, halt_i,
    input  pc_o, take_o, flush_o, halted_o, ge_q_o, ne_q_o
  );

  modport slave (
    input  stall_i, flag_we_i, ge_i, ne_i, br_valid_i, br_cond_i, br_target_i, halt_i,
    output pc_o, take_o, flush_o, halted_o, ge_q_o, ne_q_o
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Program counter, compare-flag register and branch resolution.
// Also generates the post-branch flush window and the HALT state.
module branch_pc_unit #(
  parameter int unsigned PCW       = 10,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic        clk,
  input logic        rst_n,
  branch_pc_if.slave bus
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           ge_q, ge_d;
  logic           ne_q, ne_d;
  logic           take_q, take_d;
  logic           flush_q, flush_d;
  logic           ge_eff, ne_eff, taken;

  // A CMP in the same cycle as the branch is forwarded straight from the ALU.
  always_comb begin
    ge_eff = bus.flag_we_i ? bus.ge_i : ge_q;
    ne_eff = bus.flag_we_i ? bus.ne_i : ne_q;
    case (bus.br_cond_i)
      2'b00:   taken = 1'b1;
      2'b01:   taken = ne_eff;
      2'b10:   taken = ge_eff;
      default: taken = ~ge_eff;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ge_d    = ge_q;
    ne_d    = ne_q;
    take_d  = take_q;
    flush_d = flush_q;
    if (!bus.stall_i) begin
      case (state_q)
        StRun: begin
          take_d  = 1'b0;
          flush_d = 1'b0;
          if (bus.flag_we_i) begin
            ge_d = bus.ge_i;
            ne_d = bus.ne_i;
          end
          if (bus.halt_i) begin
            state_d = StHalt;
          end else if (bus.br_valid_i && taken) begin
            pc_d    = bus.br_target_i;
            take_d  = 1'b1;
            flush_d = 1'b1;
            cnt_d   = 3'(FLUSH_CYC - 1);
            // With a single bubble the flush ends on the next edge, so RUN handles it.
            if (FLUSH_CYC > 1) state_d = StFlush;
          end else begin
            pc_d = pc_q + PCW'(1);
          end
        end
        StFlush: begin
          pc_d   = pc_q + PCW'(1);
          take_d = 1'b0;
          if (cnt_q == 3'd0) begin
            state_d = StRun;
            flush_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        StHalt: ;
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= PCW'(RESET_PC);
      cnt_q   <= 3'd0;
      ge_q    <= 1'b1;
      ne_q    <= 1'b0;
      take_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ge_q    <= ge_d;
      ne_q    <= ne_d;
      take_q  <= take_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_o     = pc_q;
  assign bus.take_o   = take_q;
  assign bus.flush_o  = flush_q;
  assign bus.halted_o = (state_q == StHalt);
  assign bus.ge_q_o   = ge_q;
  assign bus.ne_q_o   = ne_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed test of branch_pc_unit with hand-computed expected values.
module tb_branch_pc_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  branch_pc_if #(.PCW(10)) bus ();

  branch_pc_unit #(.PCW(10), .RESET_PC(0), .FLUSH_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall_i     = 1'b0;
    bus.flag_we_i   = 1'b0;
    bus.ge_i        = 1'b0;
    bus.ne_i        = 1'b0;
    bus.br_valid_i  = 1'b0;
    bus.br_cond_i   = 2'b00;
    bus.br_target_i = '0;
    bus.halt_i      = 1'b0;
  endtask

  task automatic branch(input logic [1:0] cond, input logic [9:0] tgt);
    bus.br_valid_i  = 1'b1;
    bus.br_cond_i   = cond;
    bus.br_target_i = tgt;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc"}, 32'(bus.pc_o), 32'h0);
    check({tag, ".ge"}, 32'(bus.ge_q_o), 32'h1);
    check({tag, ".ne"}, 32'(bus.ne_q_o), 32'h0);
    check({tag, ".take"}, 32'(bus.take_o), 32'h0);
    check({tag, ".flush"}, 32'(bus.flush_o), 32'h0);
    check({tag, ".halted"}, 32'(bus.halted_o), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    step();
    check_reset("rst");
    rst_n = 1'b1;

    // Free-running increment
    for (int i = 1; i <= 3; i++) begin
      step();
      check("inc.pc", 32'(bus.pc_o), 32'(i));
    end
    bus.flag_we_i = 1'b1; bus.ge_i = 1'b0; bus.ne_i = 1'b1;
    step();
    check("cmp.pc", 32'(bus.pc_o), 32'h4);
    check("cmp.ge", 32'(bus.ge_q_o), 32'h0);
    check("cmp.ne", 32'(bus.ne_q_o), 32'h1);
    check("cmp.flush", 32'(bus.flush_o), 32'h0);

    // BLT taken on ge=0
    idle();
    branch(2'b11, 10'h040);
    step();
    check("blt.pc", 32'(bus.pc_o), 32'h40);
    check("blt.take", 32'(bus.take_o), 32'h1);
    check("blt.flush", 32'(bus.flush_o), 32'h1);

    // Branch, halt and CMP in the flush window are squashed
    branch(2'b00, 10'h100);
    bus.halt_i = 1'b1;
    bus.flag_we_i = 1'b1; bus.ge_i = 1'b1; bus.ne_i = 1'b0;
    step();
    check("fl1.pc", 32'(bus.pc_o), 32'h41);
    check("fl1.take", 32'(bus.take_o), 32'h0);
    check("fl1.flush", 32'(bus.flush_o), 32'h1);
    check("fl1.halted", 32'(bus.halted_o), 32'h0);
    check("fl1.ge", 32'(bus.ge_q_o), 32'h0);
    idle();
    step();
    check("fl2.pc", 32'(bus.pc_o), 32'h42);
    check("fl2.flush", 32'(bus.flush_o), 32'h0);
    check("fl2.halted", 32'(bus.halted_o), 32'h0);

    // Halt beats a simultaneous taken branch
    bus.halt_i = 1'b1;
    branch(2'b00, 10'h200);
    step();
    check("halt.pc", 32'(bus.pc_o), 32'h42);
    check("halt.halted", 32'(bus.halted_o), 32'h1);
    check("halt.take", 32'(bus.take_o), 32'h0);
    idle();
    branch(2'b00, 10'h300);
    bus.flag_we_i = 1'b1; bus.ge_i = 1'b1; bus.ne_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold.pc", 32'(bus.pc_o), 32'h42);
      check("hold.halted", 32'(bus.halted_o), 32'h1);
    end
    check("hold.ne", 32'(bus.ne_q_o), 32'h1);
    check("hold.ge", 32'(bus.ge_q_o), 32'h0);
    idle();
    rst_n = 1'b0;
    #1;
    check_reset("rst2");
    rst_n = 1'b1;

    // Forwarding: registered ne=1 but the same-cycle CMP gives ne=0
    bus.flag_we_i = 1'b1; bus.ge_i = 1'b0; bus.ne_i = 1'b1;
    step();
    check("fw0.pc", 32'(bus.pc_o), 32'h1);
    check("fw0.ne", 32'(bus.ne_q_o), 32'h1);
    bus.ge_i = 1'b1; bus.ne_i = 1'b0;
    branch(2'b01, 10'h010);
    step();
    check("fw.pc", 32'(bus.pc_o), 32'h2);
    check("fw.take", 32'(bus.take_o), 32'h0);
    check("fw.ne", 32'(bus.ne_q_o), 32'h0);
    check("fw.ge", 32'(bus.ge_q_o), 32'h1);

    // Stall in mid-flush freezes everything, including take_o
    idle();
    branch(2'b10, 10'h3f0);
    step();
    check("bge.pc", 32'(bus.pc_o), 32'h3f0);
    check("bge.take", 32'(bus.take_o), 32'h1);
    bus.stall_i = 1'b1;
    branch(2'b00, 10'h123);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.pc", 32'(bus.pc_o), 32'h3f0);
      check("stall.flush", 32'(bus.flush_o), 32'h1);
      check("stall.take", 32'(bus.take_o), 32'h1);
    end
    idle();
    step();
    check("post1.pc", 32'(bus.pc_o), 32'h3f1);
    check("post1.flush", 32'(bus.flush_o), 32'h1);
    check("post1.take", 32'(bus.take_o), 32'h0);
    step();
    check("post2.pc", 32'(bus.pc_o), 32'h3f2);
    check("post2.flush", 32'(bus.flush_o), 32'h0);

    // PC wrap
    for (int i = 0; i < 13; i++) step();
    check("wrap.pre", 32'(bus.pc_o), 32'h3ff);
    step();
    check("wrap.pc", 32'(bus.pc_o), 32'h0);

    // Asynchronous reset in the middle of a flush
    branch(2'b00, 10'h080);
    step();
    check("ar.pc", 32'(bus.pc_o), 32'h80);
    check("ar.flush", 32'(bus.flush_o), 32'h1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    rst_n = 1'b1;
    step();
    check("arst.run", 32'(bus.pc_o), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Sits directly downstream of the ALU. Consumes the ALU compare flags (ge/ne) and holds them in an architectural flag register.
- Resolves conditional branches against those flags, owns the program counter, and drives the pipeline flush/bubble window after a taken branch.
- Also implements the HALT condition.

Parameters:
PCW, 10, program counter width in bits
RESET_PC, 0, PC value loaded on reset
FLUSH_CYC, 2, number of bubble cycles after a taken branch (1..7)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  freeze all state (PC, flags, FSM, flush counter)
flag_we_i  in  1  ALU executing CMP this cycle; capture flags
ge_i  in  1  ALU greater-or-equal flag
ne_i  in  1  ALU not-equal flag
br_valid_i  in  1  branch instruction present this cycle
br_cond_i  in  2  00 always, 01 BNE (ne), 10 BGE (ge), 11 BLT (!ge)
br_target_i  in  PCW  absolute branch target
halt_i  in  1  HALT instruction present this cycle
pc_o  out  PCW  current fetch PC
take_o  out  1  registered pulse: branch was taken last cycle
flush_o  out  1  bubble downstream fetch/decode this cycle
halted_o  out  1  processor halted
ge_q_o  out  1  registered ge flag
ne_q_o  out  1  registered ne flag

Behaviour:
- Reset (async, rst_n=0): pc_o=RESET_PC, ge_q_o=1, ne_q_o=0 (the flags of 0-0), take_o=0, flush_o=0, halted_o=0, FSM=RUN, flush counter=0. Reset mid-flush or mid-halt returns to RUN immediately.
- FSM states: RUN, FLUSH, HALT.
- Priority each edge: reset > stall > halt > branch > increment.
- stall_i=1: every register holds its value, including take_o. flush_o holds its level. Inputs are ignored.
- Flag register:
  - In RUN with flag_we_i=1 and no stall, ge_q/ne_q load ge_i/ne_i.
  - Flags are not written in FLUSH or HALT.
- Flag forwarding: when flag_we_i and br_valid_i are asserted in the same cycle, the condition evaluates on ge_i/ne_i, not on the registered flags.
- Condition: taken = (cond==00) | (cond==01 & ne) | (cond==10 & ge) | (cond==11 & !ge).
- RUN:
  - halt_i=1 -> HALT. pc holds; halted_o=1 from the next cycle.
  - Else br_valid_i & taken -> pc<=br_target_i, take_o<=1, flush_o<=1, counter<=FLUSH_CYC-1. Go to FLUSH, or stay in RUN with flush_o cleared the following cycle if FLUSH_CYC==1.
  - Else pc<=pc+1 (mod 2^PCW), take_o<=0.
  - An untaken branch behaves exactly like an increment.
- FLUSH:
  - pc<=pc+1 each cycle. flush_o=1. take_o<=0.
  - br_valid_i, halt_i and flag_we_i are ignored: the instructions are squashed.
  - At counter==0, go to RUN and deassert flush_o on the same edge.
  - Total flush_o high time is exactly FLUSH_CYC non-stalled cycles.
- HALT: pc, flags and outputs frozen; halted_o=1. Only reset exits.
- PC wrap: 2^PCW-1 increments to 0 with no flag or error.
- Latency:
  - Branch decision is registered: target appears on pc_o 1 cycle after br_valid_i.
  - take_o is a single-cycle pulse aligned with the new pc_o.
- halt_i and a taken branch in the same RUN cycle: halt wins and pc holds.

Test Plan:
1. Reset release, 5 free cycles -> pc_o 0,1,2,3,4. Flags ge=1, ne=0. flush_o=0.
2. flag_we with ge=0, ne=1 at pc=3, then BLT to 0x40 at pc=4 -> pc_o=0x40 next cycle, take_o pulses once, flush_o high exactly 2 cycles (pc 0x40, 0x41), RUN at pc 0x42.
3. Same cycle: flag_we with ge=1, ne=0 plus BNE to 0x10 -> forwarded ne=0, not taken, pc increments, ne_q_o=0 afterwards.
4. br_valid and halt_i asserted inside the FLUSH window -> ignored. Then halt_i in RUN at pc=0x42 -> halted_o=1, pc frozen at 0x42 for 10 cycles. Then rst_n pulse -> pc=0, halted_o=0.
5. stall_i high for 3 cycles in mid-FLUSH -> pc, flush_o and counter frozen. After release the remaining flush cycles complete, with total flush_o high time of 2 non-stalled cycles.
6. PC at 0x3FF, no branch -> pc_o=0x000. Assert rst_n=0 asynchronously mid-cycle during FLUSH -> outputs return to reset values before the next clock edge.
